// File: rtl/efuse_pkg.sv
// Types and constants shared by the eFuse read sequencer and the program-side AEN logic.
package efuse_pkg;

    localparam int TCNT_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_OUTPUT = 3'd4,
        ST_DONE   = 3'd5
    } efuse_state_e;

    // A programmed length of 0 still yields a one-cycle phase, so the terminal count is max(t,1)-1.
    function automatic logic [TCNT_W-1:0] phase_last(input logic [TCNT_W-1:0] t);
        return (t == '0) ? '0 : t - TCNT_W'(1);
    endfunction

endpackage

// File: rtl/efuse_rd_seq_if.sv
// Load/terminal-count handshake between the sequencer FSM and its phase timer.
interface efuse_rd_seq_if;
    import efuse_pkg::*;

    logic              load;
    logic [TCNT_W-1:0] len;
    logic              last;

    modport master (output load, output len, input last);
    modport slave  (input load, input len, output last);

endinterface

// File: rtl/efuse_phase_timer.sv
// Phase timer: loads a terminal count on every phase entry, counts up and flags the phase's last cycle.
module efuse_phase_timer
    import efuse_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    efuse_rd_seq_if.slave tmr_if
);

    logic [TCNT_W-1:0] cnt_q, cnt_d;
    logic [TCNT_W-1:0] len_q, len_d;

    always_comb begin
        cnt_d = cnt_q + TCNT_W'(1);
        len_d = len_q;
        if (tmr_if.load) begin
            cnt_d = '0;
            len_d = tmr_if.len;
        end else if (cnt_q == len_q) begin
            // Park on the terminal count while the FSM waits in an untimed state.
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

    assign tmr_if.last = (cnt_q == len_q);

endmodule

// File: rtl/efuse_rd_seq.sv
// eFuse read sequencer: SETUP/STROBE/HOLD timing per word, ready/valid output, address wrap.
// Optional abort input enabled by defining EFUSE_RD_ABORT_EN.
module efuse_rd_seq
    import efuse_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rg_efuse_rd_start,
`ifdef EFUSE_RD_ABORT_EN
    input  logic          rg_efuse_rd_abort,
`endif
    input  logic [AW-1:0] rg_efuse_rd_addr,
    input  logic [AW-1:0] rg_efuse_rd_len,
    input  logic [3:0]    rg_efuse_tsu,
    input  logic [9:0]    rg_efuse_trd,
    input  logic [3:0]    rg_efuse_thd,
    output logic          efuse_rden,
    output logic          efuse_aen,
    output logic [AW-1:0] efuse_addr,
    input  logic [DW-1:0] efuse_dout,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_busy,
    output logic          rd_done
);

    efuse_state_e      state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [AW-1:0]     words_q, words_d;
    logic [DW-1:0]     rd_data_q, rd_data_d;
    logic [TCNT_W-1:0] tmr_len;
`ifdef EFUSE_RD_ABORT_EN
    logic              abort_q, abort_d;
`endif

    efuse_rd_seq_if tmr_if ();

    efuse_phase_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .tmr_if (tmr_if)
    );

    // Timing registers are sampled as the phase is entered, so mid-phase writes take effect next phase.
    always_comb begin
        case (state_d)
            ST_SETUP:  tmr_len = phase_last(TCNT_W'(rg_efuse_tsu));
            ST_STROBE: tmr_len = phase_last(rg_efuse_trd);
            ST_HOLD:   tmr_len = phase_last(TCNT_W'(rg_efuse_thd));
            default:   tmr_len = '0;
        endcase
    end

    assign tmr_if.load = (state_d != state_q);
    assign tmr_if.len  = tmr_len;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        words_d   = words_q;
        rd_data_d = rd_data_q;
`ifdef EFUSE_RD_ABORT_EN
        abort_d   = abort_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rg_efuse_rd_start) begin
                    addr_d  = rg_efuse_rd_addr;
                    words_d = rg_efuse_rd_len;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_if.last) state_d = ST_STROBE;
`ifdef EFUSE_RD_ABORT_EN
                if (rg_efuse_rd_abort) state_d = ST_DONE;
`endif
            end
            ST_STROBE: begin
                if (tmr_if.last) begin
                    rd_data_d = efuse_dout;
                    state_d   = ST_HOLD;
                end
`ifdef EFUSE_RD_ABORT_EN
                if (rg_efuse_rd_abort) abort_d = 1'b1;
`endif
            end
            ST_HOLD: begin
                if (tmr_if.last) begin
                    state_d = ST_OUTPUT;
`ifdef EFUSE_RD_ABORT_EN
                    // A strobe already started is finished cleanly; the word is then dropped.
                    if (abort_q || rg_efuse_rd_abort) state_d = ST_DONE;
`endif
                end
`ifdef EFUSE_RD_ABORT_EN
                if (rg_efuse_rd_abort) abort_d = 1'b1;
`endif
            end
            ST_OUTPUT: begin
                if (rd_ready) begin
                    if (words_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        words_d = words_q - AW'(1);
                        state_d = ST_SETUP;
                    end
                end
`ifdef EFUSE_RD_ABORT_EN
                if (rg_efuse_rd_abort) state_d = ST_DONE;
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef EFUSE_RD_ABORT_EN
                abort_d = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            words_q   <= '0;
            rd_data_q <= '0;
`ifdef EFUSE_RD_ABORT_EN
            abort_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            words_q   <= words_d;
            rd_data_q <= rd_data_d;
`ifdef EFUSE_RD_ABORT_EN
            abort_q   <= abort_d;
`endif
        end
    end

    assign efuse_rden = (state_q == ST_SETUP) || (state_q == ST_STROBE) ||
                        (state_q == ST_HOLD)  || (state_q == ST_OUTPUT);
    assign efuse_aen  = (state_q == ST_STROBE);
    assign efuse_addr = addr_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = (state_q == ST_OUTPUT);
    assign rd_busy    = (state_q != ST_IDLE);
    assign rd_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_efuse_rd_seq.sv
// Directed bench for efuse_rd_seq; eFuse macro model returns (addr ^ 0xA5) + strobe-cycle index.
module tb_efuse_rd_seq;

    logic       clk;
    logic       rst;
    logic       rg_efuse_rd_start;
`ifdef EFUSE_RD_ABORT_EN
    logic       rg_efuse_rd_abort;
`endif
    logic [7:0] rg_efuse_rd_addr;
    logic [7:0] rg_efuse_rd_len;
    logic [3:0] rg_efuse_tsu;
    logic [9:0] rg_efuse_trd;
    logic [3:0] rg_efuse_thd;
    logic       efuse_rden;
    logic       efuse_aen;
    logic [7:0] efuse_addr;
    logic [7:0] efuse_dout;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       rd_busy;
    logic       rd_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc;

    int         aen_cyc, rden_cyc, valid_cyc, hs_cnt, done_cnt, done_cyc;
    logic       aen_prev = 1'b0;
    logic [7:0] aen_run  = 8'd0;
    logic [7:0] addr_log[$];
    logic [7:0] data_log[$];
    int         hs_cyc_log[$];

    efuse_rd_seq #(.AW(8), .DW(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .rg_efuse_rd_start (rg_efuse_rd_start),
`ifdef EFUSE_RD_ABORT_EN
        .rg_efuse_rd_abort (rg_efuse_rd_abort),
`endif
        .rg_efuse_rd_addr  (rg_efuse_rd_addr),
        .rg_efuse_rd_len   (rg_efuse_rd_len),
        .rg_efuse_tsu      (rg_efuse_tsu),
        .rg_efuse_trd      (rg_efuse_trd),
        .rg_efuse_thd      (rg_efuse_thd),
        .efuse_rden        (efuse_rden),
        .efuse_aen         (efuse_aen),
        .efuse_addr        (efuse_addr),
        .efuse_dout        (efuse_dout),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready),
        .rd_busy           (rd_busy),
        .rd_done           (rd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        aen_run <= efuse_aen ? aen_run + 8'd1 : 8'd0;
    end

    assign efuse_dout = (efuse_addr ^ 8'hA5) + aen_run;

    always @(negedge clk) begin
        if (efuse_aen) aen_cyc++;
        if (efuse_rden) rden_cyc++;
        if (rd_valid) valid_cyc++;
        if (efuse_aen && !aen_prev) addr_log.push_back(efuse_addr);
        if (rd_valid && rd_ready) begin
            hs_cnt++;
            data_log.push_back(rd_data);
            hs_cyc_log.push_back(cyc);
        end
        if (rd_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        aen_prev = efuse_aen;
    end

    task automatic clear_mon();
        aen_cyc = 0; rden_cyc = 0; valid_cyc = 0; hs_cnt = 0; done_cnt = 0; done_cyc = 0;
        addr_log.delete(); data_log.delete(); hs_cyc_log.delete();
    endtask

    task automatic start_seq(input logic [7:0] a, input logic [7:0] l, input logic [3:0] su,
                             input logic [9:0] rd, input logic [3:0] hd);
        rg_efuse_rd_addr  = a;
        rg_efuse_rd_len   = l;
        rg_efuse_tsu      = su;
        rg_efuse_trd      = rd;
        rg_efuse_thd      = hd;
        rg_efuse_rd_start = 1'b1;
        start_cyc         = cyc;
        @(posedge clk); #1;
        rg_efuse_rd_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (done_cnt == 0) begin bad++; $display("FAIL %s_timeout: no rd_done within %0d cycles", name, budget); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (efuse_rden !== 1'b0) begin bad++; $display("FAIL reset_rden got=%b exp=0", efuse_rden); end
        total++; if (efuse_aen  !== 1'b0) begin bad++; $display("FAIL reset_aen got=%b exp=0", efuse_aen); end
        total++; if (efuse_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", efuse_addr); end
        total++; if (rd_data    !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rd_data); end
        total++; if (rd_valid   !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
        total++; if (rd_busy    !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", rd_busy); end
        total++; if (rd_done    !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", rd_done); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        clear_mon();
        rd_ready = 1'b1;
        start_seq(8'h10, 8'd0, 4'd2, 10'd5, 4'd1);
        wait_done(60, "single");
        total++; if (aen_cyc !== 5) begin bad++; $display("FAIL single_aen_cycles got=%0d exp=5", aen_cyc); end
        total++; if (rden_cyc !== 9) begin bad++; $display("FAIL single_rden_cycles got=%0d exp=9", rden_cyc); end
        total++; if (hs_cnt !== 1) begin bad++; $display("FAIL single_handshakes got=%0d exp=1", hs_cnt); end
        total++; if (data_log.size() < 1 || data_log[0] !== 8'hB9) begin
            bad++; $display("FAIL single_data got=%h exp=b9", (data_log.size() > 0) ? data_log[0] : 8'hxx); end
        total++; if (hs_cyc_log.size() < 1 || hs_cyc_log[0] - start_cyc !== 9) begin
            bad++; $display("FAIL single_latency got=%0d exp=9", (hs_cyc_log.size() > 0) ? hs_cyc_log[0] - start_cyc : -1); end
        total++; if (done_cnt !== 1 || hs_cyc_log.size() < 1 || done_cyc !== hs_cyc_log[0] + 1) begin
            bad++; $display("FAIL single_done got_cnt=%0d got_cyc=%0d exp_cnt=1 exp_cyc=hs+1", done_cnt, done_cyc); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        logic [7:0] exp_data [4] = '{8'h5C, 8'h5B, 8'hA6, 8'hA5};
        clear_mon();
        rd_ready = 1'b1;
        start_seq(8'hFE, 8'd3, 4'd3, 10'd2, 4'd2);
        wait_done(120, "wrap");
        for (int i = 0; i < 4; i++) begin
            total++; if (i >= addr_log.size() || addr_log[i] !== exp_addr[i]) begin
                bad++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, (i < addr_log.size()) ? addr_log[i] : 8'hxx, exp_addr[i]); end
            total++; if (i >= data_log.size() || data_log[i] !== exp_data[i]) begin
                bad++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, (i < data_log.size()) ? data_log[i] : 8'hxx, exp_data[i]); end
        end
        total++; if (hs_cnt !== 4) begin bad++; $display("FAIL wrap_handshakes got=%0d exp=4", hs_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL wrap_done got=%0d exp=1", done_cnt); end
        total++; if (hs_cyc_log.size() < 2 || hs_cyc_log[1] - hs_cyc_log[0] !== 8) begin
            bad++; $display("FAIL wrap_word_latency got=%0d exp=8", (hs_cyc_log.size() > 1) ? hs_cyc_log[1] - hs_cyc_log[0] : -1); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int unstable = 0;
        clear_mon();
        rd_ready = 1'b0;
        start_seq(8'h33, 8'd1, 4'd1, 10'd2, 4'd1);
        while (!rd_valid && n < 50) begin @(posedge clk); #1; n++; end
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_timeout got=%b exp=1", rd_valid); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rd_valid !== 1'b1 || rd_data !== 8'h97) unstable++;
        end
        total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable got=%0d unstable cycles exp=0", unstable); end
        total++; if (rd_data !== 8'h97) begin bad++; $display("FAIL bp_data got=%h exp=97", rd_data); end
        total++; if (aen_cyc !== 2) begin bad++; $display("FAIL bp_no_strobe got=%0d aen cycles exp=2", aen_cyc); end
        rd_ready = 1'b1;
        wait_done(60, "bp");
        total++; if (hs_cnt !== 2) begin bad++; $display("FAIL bp_handshakes got=%0d exp=2", hs_cnt); end
        total++; if (data_log.size() < 2 || data_log[1] !== 8'h92) begin
            bad++; $display("FAIL bp_data2 got=%h exp=92", (data_log.size() > 1) ? data_log[1] : 8'hxx); end
        total++; if (aen_cyc !== 4) begin bad++; $display("FAIL bp_aen_total got=%0d exp=4", aen_cyc); end
    endtask

    task automatic test_min_timing();
        clear_mon();
        rd_ready = 1'b1;
        start_seq(8'h40, 8'd1, 4'd0, 10'd0, 4'd0);
        @(posedge clk); #1;
        rg_efuse_rd_addr  = 8'h80;
        rg_efuse_rd_start = 1'b1;
        @(posedge clk); #1;
        rg_efuse_rd_start = 1'b0;
        wait_done(40, "min");
        total++; if (aen_cyc !== 2) begin bad++; $display("FAIL min_aen got=%0d exp=2", aen_cyc); end
        total++; if (addr_log.size() != 2 || addr_log[0] !== 8'h40 || addr_log[1] !== 8'h41) begin
            bad++; $display("FAIL min_addr got_n=%0d first=%h exp=2 words 40,41", addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 8'hxx); end
        total++; if (data_log.size() != 2 || data_log[0] !== 8'hE5 || data_log[1] !== 8'hE4) begin
            bad++; $display("FAIL min_data got_n=%0d first=%h exp=e5,e4", data_log.size(), (data_log.size() > 0) ? data_log[0] : 8'hxx); end
        total++; if (hs_cyc_log.size() < 2 || hs_cyc_log[0] - start_cyc !== 4 || hs_cyc_log[1] - hs_cyc_log[0] !== 4) begin
            bad++; $display("FAIL min_latency got_n=%0d exp first=4 step=4", hs_cyc_log.size()); end
        repeat (5) @(posedge clk);
        #1;
        total++; if (done_cnt !== 1 || rd_busy !== 1'b0) begin
            bad++; $display("FAIL min_start_ignored got_done=%0d busy=%b exp=1,0", done_cnt, rd_busy); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_mon();
        rd_ready = 1'b1;
        start_seq(8'h20, 8'd2, 4'd1, 10'd6, 4'd1);
        while (!efuse_aen && n < 30) begin @(posedge clk); #1; n++; end
        total++; if (efuse_aen !== 1'b1) begin bad++; $display("FAIL rstmid_strobe_timeout got=%b exp=1", efuse_aen); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if ({efuse_rden, efuse_aen, rd_valid, rd_busy, rd_done} !== 5'b0) begin
            bad++; $display("FAIL rstmid_ctrl got=%b exp=00000", {efuse_rden, efuse_aen, rd_valid, rd_busy, rd_done}); end
        total++; if (efuse_addr !== 8'h00 || rd_data !== 8'h00) begin
            bad++; $display("FAIL rstmid_regs got addr=%h data=%h exp=00,00", efuse_addr, rd_data); end
        rst = 1'b0;
        @(posedge clk); #1;
        clear_mon();
        start_seq(8'h50, 8'd0, 4'd1, 10'd1, 4'd1);
        wait_done(30, "restart");
        total++; if (hs_cnt !== 1 || data_log.size() < 1 || data_log[0] !== 8'hF5) begin
            bad++; $display("FAIL restart_data got_n=%0d data=%h exp=1,f5", hs_cnt, (data_log.size() > 0) ? data_log[0] : 8'hxx); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL restart_done got=%0d exp=1", done_cnt); end
    endtask

`ifdef EFUSE_RD_ABORT_EN
    task automatic test_abort();
        int n = 0;
        clear_mon();
        rd_ready = 1'b1;
        start_seq(8'h60, 8'd2, 4'd1, 10'd4, 4'd2);
        while (!efuse_aen && n < 30) begin @(posedge clk); #1; n++; end
        rg_efuse_rd_abort = 1'b1;
        @(posedge clk); #1;
        rg_efuse_rd_abort = 1'b0;
        wait_done(40, "abort_strobe");
        total++; if (aen_cyc !== 4) begin bad++; $display("FAIL abort_strobe_aen got=%0d exp=4", aen_cyc); end
        total++; if (valid_cyc !== 0 || hs_cnt !== 0) begin
            bad++; $display("FAIL abort_strobe_valid got=%0d exp=0", valid_cyc); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL abort_strobe_done got=%0d exp=1", done_cnt); end
        clear_mon();
        rd_ready = 1'b0;
        n = 0;
        start_seq(8'h70, 8'd1, 4'd1, 10'd1, 4'd1);
        while (!rd_valid && n < 30) begin @(posedge clk); #1; n++; end
        rg_efuse_rd_abort = 1'b1;
        @(posedge clk); #1;
        rg_efuse_rd_abort = 1'b0;
        total++; if (rd_valid !== 1'b0 || rd_done !== 1'b1) begin
            bad++; $display("FAIL abort_output got valid=%b done=%b exp=0,1", rd_valid, rd_done); end
        @(posedge clk); #1;
        total++; if (rd_busy !== 1'b0 || hs_cnt !== 0) begin
            bad++; $display("FAIL abort_output_idle got busy=%b hs=%0d exp=0,0", rd_busy, hs_cnt); end
        rd_ready = 1'b1;
    endtask
`endif

    initial begin
        rst               = 1'b1;
        rg_efuse_rd_start = 1'b0;
`ifdef EFUSE_RD_ABORT_EN
        rg_efuse_rd_abort = 1'b0;
`endif
        rg_efuse_rd_addr  = 8'h00;
        rg_efuse_rd_len   = 8'h00;
        rg_efuse_tsu      = 4'd0;
        rg_efuse_trd      = 10'd0;
        rg_efuse_thd      = 4'd0;
        rd_ready          = 1'b1;
        clear_mon();
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_min_timing();
        test_reset_mid();
`ifdef EFUSE_RD_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
